exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt initiator that drives the cp0 exception port and redirects the pipeline.
//  Sits at the commit point (end of MEM): gathers per-instruction exception flags, samples pending
//  interrupts, picks one cause by priority, waits for any outstanding data-memory access to drain,
//  then pulses cp0, flushes the pipeline and redirects fetch to the handler or to EPC (ERET).
// PARAMETERS
//  HANDLER_PC  32'hBFC0_0380  general exception/interrupt vector (BEV=1)
//  EXC_W       5              exccode width; codes come from cp0.vh (Int, AdEL, AdES, Sys, Bp, RI, Ov, ERET)
// PORTS
//  clk               in   1   clock; all state on posedge
//  resetn            in   1   asynchronous, active-low reset
//  commit_valid      in   1   valid instruction at commit this cycle
//  commit_pc         in   32  its PC
//  commit_ds         in   1   it sits in a branch delay slot
//  f_adel            in   1   fetch address error (badvaddr = commit_pc)
//  d_ri, d_sys, d_bp in   1   reserved instr / syscall / break
//  e_ov              in   1   arithmetic overflow
//  m_adel, m_ades    in   1   load / store address error
//  m_vaddr           in   32  data virtual address for m_adel/m_ades
//  d_eret            in   1   instruction is ERET
//  mem_busy          in   1   data-memory transaction outstanding; no flush while high
//  status_ie/exl     in   1   from cp0
//  status_im,cause_ip in  8   from cp0
//  epc               in   32  from cp0
//  exception         out  1   one-cycle pulse to cp0
//  exccode           out  5   cause code, valid with exception
//  exc_pc            out  32  PC to cp0, valid with exception
//  exc_ds            out  1   delay-slot flag to cp0
//  badvaddr          out  32  faulting address, valid with exception
//  stall             out  1   hold commit stage and everything upstream
//  flush             out  1   kill all in-flight instructions (IF..MEM)
//  redirect_valid    out  1   one-cycle fetch redirect
//  redirect_pc       out  32  new fetch PC
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE; every output 0; captured registers 0.
//  int_pend = status_ie & ~status_exl & |(status_im & cause_ip), combinational from cp0 state.
//  Taken event when commit_valid & (int_pend | any flag | d_eret). Priority, highest first:
//   Int > f_adel(AdEL, bva=commit_pc) > d_ri(RI) > e_ov(Ov) > d_sys(Sys) > d_bp(Bp)
//   > m_adel(AdEL, bva=m_vaddr) > m_ades(AdES, bva=m_vaddr) > d_eret(ERET).
//  Interrupt taken on an ERET instruction: Int wins; ERET not performed (re-executes after handler).
//  FSM states IDLE, DRAIN, SIGNAL, REDIRECT.
//   IDLE: on taken event, latch code/pc/ds/bva. mem_busy=1 -> DRAIN with stall=1;
//         mem_busy=0 -> SIGNAL next cycle with stall=1.
//   DRAIN: stall=1; latched values frozen (new int_pend/flags ignored); leave to SIGNAL when mem_busy=0.
//   SIGNAL: exception=1 (exactly one cycle), exccode/exc_pc/exc_ds/badvaddr = latched; flush=1,
//           stall=1 -> REDIRECT.
//   REDIRECT: redirect_valid=1, flush=1, stall=0; redirect_pc = ERET ? epc : HANDLER_PC
//             (epc read here, after cp0 updated it on the SIGNAL edge) -> IDLE.
//  Latency: event accepted at cycle T with mem_busy=0 -> exception at T+1, redirect at T+2.
//  Outputs exccode/exc_pc/exc_ds/badvaddr are 0 outside SIGNAL. No event accepted outside IDLE.
//  Synchronous exceptions are still signalled while status_exl=1 (cp0 keeps EPC); only Int masked.
//  commit_valid=0 -> flags ignored, even with int_pend.
//  resetn asserted mid-sequence: immediate return to IDLE; no pending exception or redirect survives.
// TESTING
//  Syscall at pc=0x8000_1000, ds=0, mem_busy=0 -> exception@T+1 exccode=Sys, exc_pc=0x8000_1000;
//   redirect@T+2 to 0xBFC0_0380; flush high T+1..T+2.
//  f_adel+d_ri+m_ades together, pc=0x8000_0002 -> single pulse, exccode=AdEL, badvaddr=0x8000_0002.
//  m_adel vaddr=0x1234_5671, mem_busy high 3 cycles -> stall 4 cycles, exception 1 cycle after
//   mem_busy falls, badvaddr=0x1234_5671; an interrupt raised during DRAIN does not change exccode.
//  ERET with epc=0x8000_2000, no int -> exccode=ERET pulse, redirect_pc=0x8000_2000.
//  status_ie=1, im=0x80, ip=0x80: exl=1 -> no event; exl=0 + ERET committing -> exccode=Int.
//  resetn low during SIGNAL -> all outputs 0 immediately; no redirect afterwards.

Source files
------------

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt initiator at the commit point (end of MEM).
//
// Gathers the per-instruction exception flags and the pending-interrupt state,
// picks one cause by priority and latches it. It then waits for any outstanding
// data-memory access to drain, pulses the cp0 exception port, flushes IF..MEM,
// and redirects fetch either to the handler vector or, for ERET, to EPC.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   commit_valid/pc/ds     instruction at commit, its PC and delay-slot flag
//   f_adel d_ri d_sys d_bp per-stage exception flags of the committing instr
//   e_ov m_adel m_ades
//   m_vaddr                data address for m_adel / m_ades
//   d_eret                 committing instruction is ERET
//   mem_busy               data-memory transaction outstanding (no flush yet)
//   status_ie/exl/im       cp0 status fields
//   cause_ip               cp0 cause.IP
//   epc                    cp0 EPC (read in REDIRECT, after cp0 updated it)
//   exception, exccode,    one-cycle cp0 exception port; the data fields are
//   exc_pc, exc_ds,        zero outside that cycle
//   badvaddr
//   stall                  hold commit and everything upstream
//   flush                  kill all in-flight instructions
//   redirect_valid/pc      one-cycle fetch redirect
// -----------------------------------------------------------------------------
module exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'hBFC0_0380,
   parameter int          EXC_W      = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             commit_valid,
   input  logic [31:0]      commit_pc,
   input  logic             commit_ds,
   input  logic             f_adel,
   input  logic             d_ri,
   input  logic             d_sys,
   input  logic             d_bp,
   input  logic             e_ov,
   input  logic             m_adel,
   input  logic             m_ades,
   input  logic [31:0]      m_vaddr,
   input  logic             d_eret,
   input  logic             mem_busy,
   input  logic             status_ie,
   input  logic             status_exl,
   input  logic [7:0]       status_im,
   input  logic [7:0]       cause_ip,
   input  logic [31:0]      epc,
   output logic             exception,
   output logic [EXC_W-1:0] exccode,
   output logic [31:0]      exc_pc,
   output logic             exc_ds,
   output logic [31:0]      badvaddr,
   output logic             stall,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc
);

   // Cause codes (cp0.vh values; ERET uses a code outside the hardware set).
   localparam logic [EXC_W-1:0] EXC_INT  = EXC_W'(5'h00);
   localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(5'h04);
   localparam logic [EXC_W-1:0] EXC_ADES = EXC_W'(5'h05);
   localparam logic [EXC_W-1:0] EXC_SYS  = EXC_W'(5'h08);
   localparam logic [EXC_W-1:0] EXC_BP   = EXC_W'(5'h09);
   localparam logic [EXC_W-1:0] EXC_RI   = EXC_W'(5'h0A);
   localparam logic [EXC_W-1:0] EXC_OV   = EXC_W'(5'h0C);
   localparam logic [EXC_W-1:0] EXC_ERET = EXC_W'(5'h1F);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DRAIN    = 2'd1;
   localparam logic [1:0] S_SIGNAL   = 2'd2;
   localparam logic [1:0] S_REDIRECT = 2'd3;

   logic [1:0]       state;
   logic [EXC_W-1:0] lat_code;
   logic [31:0]      lat_pc;
   logic             lat_ds;
   logic [31:0]      lat_bva;
   logic             lat_eret;

   logic             int_pend;
   logic             any_flag;
   logic             take;
   logic [EXC_W-1:0] ev_code;
   logic [31:0]      ev_bva;
   logic             ev_eret;

   // Interrupts are masked while EXL is set; synchronous causes are not.
   assign int_pend = status_ie & ~status_exl & (|(status_im & cause_ip));
   assign any_flag = f_adel | d_ri | d_sys | d_bp | e_ov | m_adel | m_ades;
   assign take     = commit_valid & (int_pend | any_flag | d_eret);

   // Priority select. An interrupt on an ERET wins and suppresses the ERET,
   // so the ERET re-executes after the handler returns.
   always_comb begin
      ev_code = EXC_ERET;
      ev_bva  = '0;
      ev_eret = 1'b0;
      if (int_pend)      ev_code = EXC_INT;
      else if (f_adel) begin
         ev_code = EXC_ADEL;
         ev_bva  = commit_pc;
      end
      else if (d_ri)     ev_code = EXC_RI;
      else if (e_ov)     ev_code = EXC_OV;
      else if (d_sys)    ev_code = EXC_SYS;
      else if (d_bp)     ev_code = EXC_BP;
      else if (m_adel) begin
         ev_code = EXC_ADEL;
         ev_bva  = m_vaddr;
      end
      else if (m_ades) begin
         ev_code = EXC_ADES;
         ev_bva  = m_vaddr;
      end
      else               ev_eret = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         lat_code <= '0;
         lat_pc   <= '0;
         lat_ds   <= 1'b0;
         lat_bva  <= '0;
         lat_eret <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (take) begin
               lat_code <= ev_code;
               lat_pc   <= commit_pc;
               lat_ds   <= commit_ds;
               lat_bva  <= ev_bva;
               lat_eret <= ev_eret;
               state    <= mem_busy ? S_DRAIN : S_SIGNAL;
            end
            // Latched cause is frozen here; new flags / interrupts are ignored.
            S_DRAIN:    if (!mem_busy) state <= S_SIGNAL;
            S_SIGNAL:   state <= S_REDIRECT;
            default:    state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an asynchronous reset clears them
   // in the same instant.
   always_comb begin
      exception      = (state == S_SIGNAL);
      exccode        = exception ? lat_code : '0;
      exc_pc         = exception ? lat_pc   : '0;
      exc_ds         = exception & lat_ds;
      badvaddr       = exception ? lat_bva  : '0;
      stall          = (state == S_DRAIN) | (state == S_SIGNAL);
      flush          = (state == S_SIGNAL) | (state == S_REDIRECT);
      redirect_valid = (state == S_REDIRECT);
      redirect_pc    = '0;
      if (redirect_valid) redirect_pc = lat_eret ? epc : HANDLER_PC;
   end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

   localparam logic [31:0] HANDLER = 32'hBFC0_0380;
   localparam logic [4:0] C_INT = 5'd0, C_ADEL = 5'd4, C_ADES = 5'd5, C_SYS = 5'd8,
                          C_BP = 5'd9, C_RI = 5'd10, C_OV = 5'd12, C_ERET = 5'd31;

   logic        clk = 1'b0;
   logic        resetn;
   logic        commit_valid, commit_ds, f_adel, d_ri, d_sys, d_bp, e_ov;
   logic        m_adel, m_ades, d_eret, mem_busy, status_ie, status_exl;
   logic [31:0] commit_pc, m_vaddr, epc;
   logic [7:0]  status_im, cause_ip;
   logic        exception, exc_ds, stall, flush, redirect_valid;
   logic [4:0]  exccode;
   logic [31:0] exc_pc, badvaddr, redirect_pc;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exc_ctrl dut (
      .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_ds(commit_ds), .f_adel(f_adel), .d_ri(d_ri), .d_sys(d_sys), .d_bp(d_bp),
      .e_ov(e_ov), .m_adel(m_adel), .m_ades(m_ades), .m_vaddr(m_vaddr), .d_eret(d_eret),
      .mem_busy(mem_busy), .status_ie(status_ie), .status_exl(status_exl),
      .status_im(status_im), .cause_ip(cause_ip), .epc(epc), .exception(exception),
      .exccode(exccode), .exc_pc(exc_pc), .exc_ds(exc_ds), .badvaddr(badvaddr),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      commit_valid = 0; commit_pc = 0; commit_ds = 0; f_adel = 0; d_ri = 0; d_sys = 0;
      d_bp = 0; e_ov = 0; m_adel = 0; m_ades = 0; m_vaddr = 0; d_eret = 0; mem_busy = 0;
      status_ie = 0; status_exl = 0; status_im = 0; cause_ip = 0;
   endtask

   task automatic rand_inputs();
      commit_valid = ($urandom_range(0, 7) != 0);
      commit_pc    = $urandom;
      commit_ds    = 1'($urandom_range(0, 1));
      f_adel = ($urandom_range(0, 7) == 0);
      d_ri   = ($urandom_range(0, 7) == 0);
      d_sys  = ($urandom_range(0, 5) == 0);
      d_bp   = ($urandom_range(0, 5) == 0);
      e_ov   = ($urandom_range(0, 6) == 0);
      m_adel = ($urandom_range(0, 5) == 0);
      m_ades = ($urandom_range(0, 5) == 0);
      d_eret = ($urandom_range(0, 3) == 0);
      m_vaddr    = $urandom;
      status_ie  = 1'($urandom_range(0, 1));
      status_exl = ($urandom_range(0, 3) == 0);
      status_im  = 8'($urandom);
      cause_ip   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
   endtask

   // Reference: walk the cause list in priority order, first asserted one wins.
   task automatic ref_event(output bit ev, output logic [4:0] code,
                            output logic [31:0] bva, output bit is_eret);
      bit          cond [9];
      logic [4:0]  codes [9];
      logic [31:0] bvas [9];
      bit          ipend;
      ipend = status_ie && !status_exl && ((status_im & cause_ip) != 8'h00);
      cond  = '{ipend, f_adel, d_ri, e_ov, d_sys, d_bp, m_adel, m_ades, d_eret};
      codes = '{C_INT, C_ADEL, C_RI, C_OV, C_SYS, C_BP, C_ADEL, C_ADES, C_ERET};
      bvas  = '{0, commit_pc, 0, 0, 0, 0, m_vaddr, m_vaddr, 0};
      ev = 0; code = 0; bva = 0; is_eret = 0;
      if (commit_valid) begin
         for (int i = 0; i < 9; i++) begin
            if (cond[i]) begin
               ev = 1; code = codes[i]; bva = bvas[i]; is_eret = (i == 8);
               break;
            end
         end
      end
   endtask

   // Entered 1 time unit after a posedge with the DUT idle and the commit
   // inputs already driven. b = number of cycles mem_busy stays high.
   task automatic run_txn(input string tag, input int b, input bit noise);
      bit          ev, is_eret;
      logic [4:0]  code;
      logic [31:0] bva, pc, new_epc;
      logic        ds;
      mem_busy = (b > 0);
      ref_event(ev, code, bva, is_eret);
      pc = commit_pc; ds = commit_ds;
      #1;
      chk({tag, ":idle_stall"}, 32'(stall), 0);
      chk({tag, ":idle_exc"}, 32'(exception), 0);
      @(posedge clk); #1;
      if (!ev) begin
         clear_inputs(); #1;
         chk({tag, ":noev_exc"}, 32'(exception), 0);
         chk({tag, ":noev_stall"}, 32'(stall), 0);
         chk({tag, ":noev_flush"}, 32'(flush), 0);
         return;
      end
      for (int k = 1; k <= b; k++) begin
         if (noise) rand_inputs(); else commit_valid = 0;
         mem_busy = (k < b);
         #1;
         chk({tag, ":drain_stall"}, 32'(stall), 1);
         chk({tag, ":drain_exc"}, 32'(exception), 0);
         chk({tag, ":drain_flush"}, 32'(flush), 0);
         @(posedge clk); #1;
      end
      if (noise) rand_inputs(); else commit_valid = 0;
      mem_busy = 0;
      #1;
      chk({tag, ":sig_exc"}, 32'(exception), 1);
      chk({tag, ":sig_code"}, 32'(exccode), 32'(code));
      chk({tag, ":sig_pc"}, exc_pc, pc);
      chk({tag, ":sig_ds"}, 32'(exc_ds), 32'(ds));
      chk({tag, ":sig_bva"}, badvaddr, bva);
      chk({tag, ":sig_flush"}, 32'(flush), 1);
      chk({tag, ":sig_stall"}, 32'(stall), 1);
      chk({tag, ":sig_rv"}, 32'(redirect_valid), 0);
      @(posedge clk); #1;
      new_epc = $urandom; epc = new_epc;
      if (noise) rand_inputs();
      mem_busy = 0;
      #1;
      chk({tag, ":red_rv"}, 32'(redirect_valid), 1);
      chk({tag, ":red_pc"}, redirect_pc, is_eret ? new_epc : HANDLER);
      chk({tag, ":red_flush"}, 32'(flush), 1);
      chk({tag, ":red_stall"}, 32'(stall), 0);
      chk({tag, ":red_exc"}, 32'(exception), 0);
      chk({tag, ":red_code"}, 32'(exccode), 0);
      @(posedge clk); #1;
      clear_inputs(); #1;
      chk({tag, ":post_rv"}, 32'(redirect_valid), 0);
      chk({tag, ":post_flush"}, 32'(flush), 0);
      chk({tag, ":post_exc"}, 32'(exception), 0);
   endtask

   initial begin
      clear_inputs();
      epc = 0;
      resetn = 0;
      #3;
      chk("rst_exc", 32'(exception), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_rv", 32'(redirect_valid), 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_code", 32'(exccode), 0);
      @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;

      // Syscall, no memory wait.
      commit_valid = 1; commit_pc = 32'h8000_1000; d_sys = 1;
      run_txn("sys", 0, 0);

      // Several flags at once: fetch AdEL wins, bva = pc.
      commit_valid = 1; commit_pc = 32'h8000_0002; f_adel = 1; d_ri = 1; m_ades = 1;
      m_vaddr = 32'h5555_0000;
      run_txn("multi", 0, 0);

      // Load AdEL with a 3-cycle drain; interrupt raised during drain.
      commit_valid = 1; commit_pc = 32'h8000_0040; m_adel = 1; m_vaddr = 32'h1234_5671;
      mem_busy = 1;
      #1; mem_busy = 1;
      begin
         bit          ev, er;
         logic [4:0]  c;
         logic [31:0] bv;
         ref_event(ev, c, bv, er);
         chk("drain_ref", 32'(c), 32'(C_ADEL));
      end
      run_txn("adel_drain", 3, 1);

      // ERET, no interrupt.
      commit_valid = 1; commit_pc = 32'h8000_3000; d_eret = 1;
      run_txn("eret", 0, 0);

      // Interrupt masked by EXL -> no event.
      commit_valid = 1; status_ie = 1; status_im = 8'h80; cause_ip = 8'h80; status_exl = 1;
      run_txn("int_exl", 0, 0);

      // Interrupt on an ERET: Int wins, redirect to handler.
      commit_valid = 1; commit_pc = 32'h8000_4000; status_ie = 1; status_im = 8'h80;
      cause_ip = 8'h80; d_eret = 1;
      run_txn("int_eret", 0, 0);

      // Interrupt pending but nothing committing -> ignored.
      commit_valid = 0; status_ie = 1; status_im = 8'hFF; cause_ip = 8'h01; d_sys = 1;
      run_txn("no_commit", 0, 0);

      // Reset during SIGNAL.
      commit_valid = 1; commit_pc = 32'h8000_5000; d_bp = 1;
      #1;
      @(posedge clk); #1;
      clear_inputs(); #1;
      chk("rstsig_exc_before", 32'(exception), 1);
      resetn = 0; #1;
      chk("rstsig_exc", 32'(exception), 0);
      chk("rstsig_flush", 32'(flush), 0);
      chk("rstsig_stall", 32'(stall), 0);
      chk("rstsig_code", 32'(exccode), 0);
      chk("rstsig_pc", exc_pc, 0);
      @(posedge clk); #1;
      resetn = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rstsig_rv", 32'(redirect_valid), 0);
         chk("rstsig_exc_after", 32'(exception), 0);
      end

      // Randomized transactions.
      for (int n = 0; n < 60; n++) begin
         rand_inputs();
         run_txn("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
